// File: rtl/mole_pattern_gen.sv
// mole_pattern_gen: timed rounds of random whack-a-mole patterns.
// A free-running 16-bit LFSR feeds a round FSM (IDLE/DRAW/PICK/SHOW/GAP).
// DRAW picks how many moles light up; PICK places them one per cycle by
// rejection sampling. SHOW displays the pattern and scores hits. GAP blanks
// the display between rounds.
// Handshake note: there is no valid/ready flow here. Every input is sampled
// on each rising edge of clk. Every output is a register: state, new_round,
// hit_ok and miss change only on a clock edge or on asynchronous reset.
module mole_pattern_gen #(
   parameter int          N_HOLES     = 5,
   parameter int          MAX_UP      = 2,
   parameter int          HOLD_CYCLES = 50_000_000,
   parameter int          GAP_CYCLES  = 12_500_000,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               seed_load,
   input  logic [15:0]        seed,
   input  logic [N_HOLES-1:0] hit,
   output logic [N_HOLES-1:0] state,
   output logic               new_round,
   output logic               hit_ok,
   output logic               miss
);

   localparam int IDXW = ($clog2(N_HOLES) < 1) ? 1 : $clog2(N_HOLES);
   localparam int CW   = ($clog2(MAX_UP) < 1) ? 1 : $clog2(MAX_UP);
   localparam int CNTW = CW + 1;
   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DRAW = 3'd1,
      S_PICK = 3'd2,
      S_SHOW = 3'd3,
      S_GAP  = 3'd4
   } fsm_e;

   fsm_e               fsm_q, fsm_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [N_HOLES-1:0] pat_q, pat_d;
   logic [N_HOLES-1:0] state_q, state_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic [CNTW-1:0]    tgt_q, tgt_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic               new_round_q, new_round_d;
   logic               hit_ok_q, hit_ok_d;
   logic               miss_q, miss_d;

   // Random fields taken straight from the LFSR.
   logic [CW-1:0]      draw_v;
   logic [IDXW-1:0]    pick_idx;
   logic [N_HOLES-1:0] pick_mask;
   logic               draw_ok;
   logic               pick_ok;

   assign draw_v    = lfsr_q[IDXW+CW-1 -: CW];
   assign pick_idx  = lfsr_q[IDXW-1:0];
   assign pick_mask = {{(N_HOLES-1){1'b0}}, 1'b1} << pick_idx;
   // With MAX_UP = 1 every draw is accepted and the target is forced to 1.
   assign draw_ok   = (MAX_UP == 1) || (32'(draw_v) < 32'(MAX_UP));
   assign pick_ok   = (32'(pick_idx) < 32'(N_HOLES)) && ((pat_q & pick_mask) == '0);

   // LFSR next value: free-running shift, with a zero seed replaced by SEED so it never locks up.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (seed_load) begin
         lfsr_d = (seed == 16'h0000) ? SEED : seed;
      end
   end

   // Round FSM next state, pattern building, timers and scoring pulses.
   always_comb begin
      fsm_d       = fsm_q;
      pat_d       = pat_q;
      cnt_d       = cnt_q;
      tgt_d       = tgt_q;
      timer_d     = timer_q;
      new_round_d = 1'b0;
      hit_ok_d    = 1'b0;
      miss_d      = 1'b0;
      if (!en) begin
         fsm_d   = S_IDLE;
         timer_d = '0;
      end else begin
         unique case (fsm_q)
            S_IDLE: begin
               fsm_d = S_DRAW;
            end
            S_DRAW: begin
               if (draw_ok) begin
                  tgt_d = (MAX_UP == 1) ? CNTW'(1) : CNTW'(draw_v) + CNTW'(1);
                  pat_d = '0;
                  cnt_d = '0;
                  fsm_d = S_PICK;
               end
            end
            S_PICK: begin
               if (pick_ok) begin
                  pat_d = pat_q | pick_mask;
                  cnt_d = cnt_q + CNTW'(1);
                  if ((cnt_q + CNTW'(1)) == tgt_q) begin
                     fsm_d       = S_SHOW;
                     timer_d     = '0;
                     new_round_d = 1'b1;
                  end
               end
            end
            S_SHOW: begin
               // Hits are judged against the pattern currently on display.
               pat_d    = pat_q & ~hit;
               hit_ok_d = |(hit & pat_q);
               miss_d   = |(hit & ~pat_q);
               if ((pat_d == '0) || (timer_q == TW'(HOLD_CYCLES - 1))) begin
                  fsm_d   = S_GAP;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            S_GAP: begin
               if (timer_q == TW'(GAP_CYCLES - 1)) begin
                  fsm_d   = S_DRAW;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: begin
               fsm_d   = S_IDLE;
               timer_d = '0;
            end
         endcase
      end
      // The display register shows the pattern only while the next state is SHOW.
      state_d = (fsm_d == S_SHOW) ? pat_d : '0;
   end

   // State, LFSR and output registers; reset puts everything at rest with the LFSR at SEED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q       <= S_IDLE;
         lfsr_q      <= SEED;
         pat_q       <= '0;
         state_q     <= '0;
         cnt_q       <= '0;
         tgt_q       <= '0;
         timer_q     <= '0;
         new_round_q <= 1'b0;
         hit_ok_q    <= 1'b0;
         miss_q      <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         lfsr_q      <= lfsr_d;
         pat_q       <= pat_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tgt_q       <= tgt_d;
         timer_q     <= timer_d;
         new_round_q <= new_round_d;
         hit_ok_q    <= hit_ok_d;
         miss_q      <= miss_d;
      end
   end

   assign state     = state_q;
   assign new_round = new_round_q;
   assign hit_ok    = hit_ok_q;
   assign miss      = miss_q;

endmodule

// File: tb/tb_mole_pattern_gen.sv
// Testbench for mole_pattern_gen with N_HOLES=5, MAX_UP=2, HOLD_CYCLES=8, GAP_CYCLES=4.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_mole_pattern_gen;

   localparam int          N_HOLES  = 5;
   localparam int          MAX_UP   = 2;
   localparam int          HOLD     = 8;
   localparam int          GAP      = 4;
   localparam logic [15:0] SEED_DEF = 16'hACE1;

   typedef struct packed {
      logic [4:0] start_pat;
      logic [4:0] hit_v;
      logic [4:0] exp_state;
      logic       exp_ok;
      logic       exp_miss;
   } score_vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        seed_load = 1'b0;
   logic [15:0] seed = 16'h0000;
   logic [4:0]  hit = 5'b00000;
   logic [4:0]  dut_state;
   logic        new_round;
   logic        hit_ok;
   logic        miss;

   int          n_pass = 0;
   int          n_total = 0;
   bit          last_ok;
   bit          model_abort;
   logic [15:0] m_lfsr;
   logic [4:0]  lit_mask;
   logic [4:0]  exp_q[$];
   score_vec_t  vecs[10];

   mole_pattern_gen #(
      .N_HOLES    (N_HOLES),
      .MAX_UP     (MAX_UP),
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES (GAP),
      .SEED       (SEED_DEF)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .seed_load(seed_load),
      .seed     (seed),
      .hit      (hit),
      .state    (dut_state),
      .new_round(new_round),
      .hit_ok   (hit_ok),
      .miss     (miss)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog: the run must end on its own.
   initial begin
      #950_000;
      $display("FAIL watchdog: simulation did not reach its summary (checks %0d/%0d)", n_pass, n_total);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
         last_ok = 1'b1;
      end else begin
         last_ok = 1'b0;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] q);
      return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   // One clock of the reference: LFSR steps on the edge, outputs compared on the falling edge.
   task automatic model_tick();
      @(posedge clk);
      m_lfsr = lfsr_next(m_lfsr);
      @(negedge clk);
   endtask

   task automatic model_expect(input logic [4:0] st, input logic nr);
      check("model_cycle", {24'd0, dut_state, new_round, hit_ok, miss}, {24'd0, st, nr, 2'b00});
      if (!last_ok) model_abort = 1'b1;
   endtask

   // Behavioural round generator. Call from a falling edge while the DUT is IDLE with en=1
   // and its LFSR holding 'start'. Ends on the falling edge of a DRAW cycle.
   // mode 0: plain check, 1: record patterns into exp_q, 2: compare patterns against exp_q.
   task automatic model_run(input logic [15:0] start, input int n_rounds, input int mode);
      logic [4:0] pat;
      logic [2:0] idx;
      logic       v;
      int         target;
      int         cnt;
      int         guard;
      m_lfsr      = start;
      model_abort = 1'b0;
      model_tick();
      model_expect(5'b0, 1'b0);
      for (int r = 0; r < n_rounds && !model_abort; r++) begin
         // DRAW: one bit of LFSR chooses 1 or 2 moles; both are below MAX_UP so never retried.
         v      = m_lfsr[3];
         target = (v == 1'b1) ? 2 : 1;
         pat    = 5'b0;
         cnt    = 0;
         model_tick();
         model_expect(5'b0, 1'b0);
         guard = 0;
         while (cnt < target && guard < 1000 && !model_abort) begin
            idx = m_lfsr[2:0];
            if (idx < 3'd5 && pat[idx] == 1'b0) begin
               pat[idx] = 1'b1;
               cnt++;
            end
            model_tick();
            guard++;
            if (cnt < target) model_expect(5'b0, 1'b0);
            else              model_expect(pat, 1'b1);
         end
         if (!model_abort) begin
            check("popcount", ($countones(dut_state) == 1 || $countones(dut_state) == 2), 1);
            lit_mask = lit_mask | dut_state;
            if (mode == 1) exp_q.push_back(pat);
            if (mode == 2) begin
               if (exp_q.size() > 0) check("reseed_repeat", dut_state, exp_q.pop_front());
               else check("reseed_q_underflow", exp_q.size(), 1);
            end
         end
         for (int i = 1; i < HOLD && !model_abort; i++) begin
            model_tick();
            model_expect(pat, 1'b0);
         end
         for (int i = 0; i < GAP + 1 && !model_abort; i++) begin
            model_tick();
            model_expect(5'b0, 1'b0);
         end
      end
   endtask

   // Waits (bounded) for the first SHOW cycle of a round; 'any' accepts whatever pattern appears.
   task automatic wait_round(input logic [4:0] p, input bit any, output logic [4:0] got);
      bit found;
      found = 1'b0;
      got   = 5'b0;
      for (int i = 0; i < 4000 && !found; i++) begin
         @(negedge clk);
         if (new_round === 1'b1 && (any || dut_state === p)) begin
            found = 1'b1;
            got   = dut_state;
         end
      end
      check($sformatf("round_search_%05b", p), found, 1);
   endtask

   initial begin
      logic [4:0] got;
      bit         seen;

      // Scoring vectors: patterns reachable by this LFSR with five holes.
      vecs[0] = '{5'b00110, 5'b00010, 5'b00100, 1'b1, 1'b0};
      vecs[1] = '{5'b00110, 5'b01000, 5'b00110, 1'b0, 1'b1};
      vecs[2] = '{5'b01010, 5'b01011, 5'b00000, 1'b1, 1'b1};
      vecs[3] = '{5'b10000, 5'b10000, 5'b00000, 1'b1, 1'b0};
      vecs[4] = '{5'b00011, 5'b00011, 5'b00000, 1'b1, 1'b0};
      vecs[5] = '{5'b10001, 5'b10010, 5'b00001, 1'b1, 1'b1};
      vecs[6] = '{5'b01100, 5'b00000, 5'b01100, 1'b0, 1'b0};
      vecs[7] = '{5'b11000, 5'b00111, 5'b11000, 1'b0, 1'b1};
      vecs[8] = '{5'b00100, 5'b00100, 5'b00000, 1'b1, 1'b0};
      vecs[9] = '{5'b10010, 5'b10000, 5'b00010, 1'b1, 1'b0};

      // Reset values.
      @(negedge clk);
      check("rst_state", dut_state, 0);
      check("rst_new_round", new_round, 0);
      check("rst_hit_ok", hit_ok, 0);
      check("rst_miss", miss, 0);

      // Free run from reset against the reference.
      lit_mask = 5'b0;
      en  = 1'b1;
      rst = 1'b0;
      model_run(SEED_DEF, 1000, 0);
      check("all_holes_lit", lit_mask, 5'b11111);

      // Table-driven scoring in the first SHOW cycle of a matching round.
      for (int i = 0; i < 10; i++) begin
         wait_round(vecs[i].start_pat, 1'b0, got);
         hit = vecs[i].hit_v;
         @(negedge clk);
         hit = 5'b0;
         check($sformatf("score%0d_state", i), dut_state, vecs[i].exp_state);
         check($sformatf("score%0d_hit_ok", i), hit_ok, vecs[i].exp_ok);
         check($sformatf("score%0d_miss", i), miss, vecs[i].exp_miss);
      end

      // Hit then miss within one round; pulses last one cycle.
      wait_round(5'b00110, 1'b0, got);
      hit = 5'b00010;
      @(negedge clk);
      hit = 5'b00001;
      check("seq_hit_state", dut_state, 5'b00100);
      check("seq_hit_ok", hit_ok, 1);
      check("seq_hit_miss", miss, 0);
      @(negedge clk);
      hit = 5'b0;
      check("seq_miss_state", dut_state, 5'b00100);
      check("seq_miss_ok", hit_ok, 0);
      check("seq_miss_miss", miss, 1);
      @(negedge clk);
      check("seq_idle_pulses", {hit_ok, miss}, 2'b00);
      check("seq_idle_state", dut_state, 5'b00100);

      // Clearing the last mole ends the round early; the gap stays blank for 4 cycles.
      wait_round(5'b10000, 1'b0, got);
      hit = 5'b10000;
      @(negedge clk);
      hit = 5'b0;
      check("clear_all_ok", hit_ok, 1);
      check("clear_all_state", dut_state, 0);
      for (int i = 0; i < GAP - 1; i++) begin
         @(negedge clk);
         check($sformatf("clear_gap%0d", i), {dut_state, new_round, hit_ok}, 7'd0);
      end

      // Hit on the timer-expiry edge is still scored and the round still ends.
      wait_round(5'b0, 1'b1, got);
      repeat (HOLD - 1) @(negedge clk);
      check("hold_last_cycle", dut_state, got);
      hit = ~got & 5'b11111;
      @(negedge clk);
      hit = 5'b0;
      check("expiry_state", dut_state, 0);
      check("expiry_miss", miss, 1);
      check("expiry_ok", hit_ok, 0);

      // Hits in GAP are ignored.
      wait_round(5'b0, 1'b1, got);
      repeat (HOLD) @(negedge clk);
      check("gap_blank", dut_state, 0);
      hit = 5'b11111;
      @(negedge clk);
      hit = 5'b0;
      check("gap_hit_pulses", {hit_ok, miss}, 2'b00);

      // en dropped mid-SHOW: blank next cycle, no pulses; re-raise starts a fresh round.
      wait_round(5'b0, 1'b1, got);
      @(negedge clk);
      en  = 1'b0;
      hit = 5'b11111;
      @(negedge clk);
      hit = 5'b0;
      check("en_drop_state", dut_state, 0);
      check("en_drop_pulses", {hit_ok, miss}, 2'b00);
      repeat (2) @(negedge clk);
      check("en_low_state", {dut_state, new_round}, 6'd0);
      en = 1'b1;
      @(negedge clk);
      check("reen_draw", new_round, 0);
      @(negedge clk);
      check("reen_pick", new_round, 0);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         if (new_round === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      check("reen_new_round", seen, 1);

      // Asynchronous reset mid-SHOW, with seed_load held during reset.
      wait_round(5'b0, 1'b1, got);
      hit = ~got & 5'b11111;
      @(negedge clk);
      hit = 5'b0;
      check("pre_rst_miss", miss, 1);
      check("pre_rst_state", dut_state, got);
      #2;
      rst       = 1'b1;
      seed_load = 1'b1;
      seed      = 16'h1234;
      #1;
      check("async_rst_outputs", {dut_state, new_round, hit_ok, miss}, 8'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      seed_load = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_run(SEED_DEF, 30, 0);

      // A zero seed loads the default seed.
      en        = 1'b0;
      seed_load = 1'b1;
      seed      = 16'h0000;
      @(negedge clk);
      seed_load = 1'b0;
      en        = 1'b1;
      check("seed0_idle_state", dut_state, 0);
      model_run(SEED_DEF, 20, 0);

      // Loading 16'h1234 twice gives the same pattern sequence.
      for (int pass = 1; pass <= 2; pass++) begin
         en        = 1'b0;
         seed_load = 1'b1;
         seed      = 16'h1234;
         @(negedge clk);
         seed_load = 1'b0;
         en        = 1'b1;
         model_run(16'h1234, 20, pass);
      end
      check("reseed_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
